// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, HI/LO move/read codes, default latencies.
// Also imported by the hazard unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_NONE  = 4'hF
  } mdu_op_e;

  typedef enum logic [1:0] {
    MT_HI   = 2'b00,
    MT_LO   = 2'b01,
    MT_NONE = 2'b10
  } mthilo_e;

  typedef enum logic [1:0] {
    MF_NONE = 2'b00,
    MF_HI   = 2'b01,
    MF_LO   = 2'b10
  } mfsel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MUL_CYC_DEF = 5;
  localparam int DIV_CYC_DEF = 10;

  // Only codes 0..7 are executable; 4'hF and 8..14 are dropped.
  function automatic logic op_is_valid(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Even codes are the signed variants.
  function automatic logic op_is_signed(input logic [3:0] op);
    return (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: computes the HI/LO result of a latched op
// against the current HI/LO; wr_en is low when the result must be discarded.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] next_hi,
  output logic [31:0] next_lo,
  output logic        wr_en
);

  logic        sgn;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [63:0] acc;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    sgn   = op_is_signed(op);
    // Low 64 bits of the product are identical for signed and unsigned once
    // operands are extended according to signedness.
    a_ext = {{32{sgn & a[31]}}, a};
    b_ext = {{32{sgn & b[31]}}, b};
    prod  = a_ext * b_ext;
    acc   = {hi, lo};

    // Sign-magnitude division keeps 0x80000000 / -1 well defined.
    a_neg = sgn & a[31];
    b_neg = sgn & b[31];
    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;
    b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    next_hi = hi;
    next_lo = lo;
    wr_en   = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: begin
        {next_hi, next_lo} = prod;
        wr_en = 1'b1;
      end
      OP_MADD, OP_MADDU: begin
        {next_hi, next_lo} = acc + prod;
        wr_en = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        {next_hi, next_lo} = acc - prod;
        wr_en = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        if (b != 32'd0) begin
          next_lo = quot;
          next_hi = rem;
          wr_en   = 1'b1;
        end
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: accepts one mul/div op at a time, counts its latency down,
// then commits HI/LO; also handles MTHI/MTLO, HI/LO reads and M-stage abort.
//
//   state   | meaning
//   ST_IDLE | accepting start or MTHI/MTLO
//   ST_RUN  | op in flight, cnt counts remaining cycles, commit when cnt==1
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYC = MUL_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  mthilo,
  input  logic [1:0]  mfsel,
  input  logic        clr,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic             start_ok;
  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             calc_wr;

  mdu_calc u_calc (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .hi      (hi_q),
    .lo      (lo_q),
    .next_hi (calc_hi),
    .next_lo (calc_lo),
    .wr_en   (calc_wr)
  );

  assign start_ok = start & op_is_valid(op) & ~clr & (state_q == ST_IDLE);
  assign busy     = start_ok | ((state_q == ST_RUN) & ~clr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE) begin
      // start takes priority over a simultaneous move to HI/LO
      if (start_ok) begin
        op_d    = op;
        a_d     = a;
        b_d     = b;
        cnt_d   = op_is_div(op) ? CNT_W'(DIV_CYC) : CNT_W'(MUL_CYC);
        state_d = ST_RUN;
      end else if (mthilo == MT_HI) begin
        hi_d = a;
      end else if (mthilo == MT_LO) begin
        lo_d = a;
      end
    end else begin
      if (cnt_q <= CNT_W'(1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (calc_wr) begin
          hi_d = calc_hi;
          lo_d = calc_lo;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  always_comb begin
    rdata = 32'd0;
    if (mfsel == MF_HI) begin
      rdata = hi_q;
    end else if (mfsel == MF_LO) begin
      rdata = lo_q;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, hand-written
// abort/reset/ignore sequences, and random ops against a 64-bit reference model.
module tb_mdu_ctrl;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  mthilo;
  logic [1:0]  mfsel;
  logic        clr;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl #(.MUL_CYC(MUL_N), .DIV_CYC(DIV_N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .mthilo (mthilo),
    .mfsel  (mfsel),
    .clr    (clr),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .rdata  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural result computed with plain 64-bit arithmetic.
  task automatic model_exec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, acc, p;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    acc = {m_hi, m_lo};
    if (o[0]) p = ux * uy;
    else      p = sx * sy;
    case (o)
      4'd0, 4'd1: {m_hi, m_lo} = p;
      4'd4, 4'd5: {m_hi, m_lo} = acc + p;
      4'd6, 4'd7: {m_hi, m_lo} = acc - p;
      4'd2: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      4'd3: if (y != 0) begin
        m_lo = 32'(ux / uy);
        m_hi = 32'(ux % uy);
      end
      default: ;
    endcase
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    mthilo = 2'b00; a = h;
    tick();
    mthilo = 2'b01; a = l;
    tick();
    mthilo = 2'b10;
    m_hi = h;
    m_lo = l;
  endtask

  // Issues op in the current cycle (cycle 0) and checks busy over 0..N and results at N+1.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int          n;
    logic [31:0] old_hi, old_lo;
    n = (o == 4'd2 || o == 4'd3) ? DIV_N : MUL_N;
    old_hi = m_hi;
    old_lo = m_lo;
    start = 1'b1; op = o; a = x; b = y;
    #1 chk("busy_cycle0", {31'd0, busy}, 32'd1);
    tick();
    start = 1'b0; op = 4'hF; a = $urandom; b = $urandom;
    for (int c = 1; c <= n; c++) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      if (c == n) begin
        chk("hi_before_commit", hi, old_hi);
        chk("lo_before_commit", lo, old_lo);
      end
      tick();
    end
    model_exec(o, x, y);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi_result", hi, m_hi);
    chk("lo_result", lo, m_lo);
    mfsel = 2'b01;
    #1 chk("rdata_hi", rdata, m_hi);
    mfsel = 2'b10;
    #1 chk("rdata_lo", rdata, m_lo);
    mfsel = 2'b00;
  endtask

  initial begin
    vt[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[1]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'd0,        32'd0,        32'h00000002, 32'hFFFFFFFA};
    vt[2]  = '{4'd3, 32'd100,      32'd7,        32'd0,        32'd0,        32'd2,        32'd14};
    vt[3]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[4]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'd0,        32'd0,        32'h80000000};
    vt[5]  = '{4'd2, 32'd1234,     32'd0,        32'h11,       32'h22,       32'h11,       32'h22};
    vt[6]  = '{4'd4, 32'd2,        32'd3,        32'd5,        32'd6,        32'd5,        32'd12};
    vt[7]  = '{4'd7, 32'd1,        32'd13,       32'd5,        32'd12,       32'd4,        32'hFFFFFFFF};
    vt[8]  = '{4'd2, 32'd7,        32'hFFFFFFFE, 32'd0,        32'd0,        32'd1,        32'hFFFFFFFD};
    vt[9]  = '{4'd6, 32'd2,        32'd3,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[10] = '{4'd5, 32'd1,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0};

    rst_n = 1'b0; start = 1'b0; op = 4'hF; a = '0; b = '0;
    mthilo = 2'b10; mfsel = 2'b00; clr = 1'b0;
    #22;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      set_hilo(vt[i].pre_hi, vt[i].pre_lo);
      run_op(vt[i].op, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d_hi", i), hi, vt[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vt[i].exp_lo);
    end

    // Abort mid-run: busy drops in the clr cycle, HI/LO untouched, next op runs normally
    set_hilo(32'hAAAA, 32'hBBBB);
    start = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0; op = 4'hF;
    tick();
    tick();
    clr = 1'b1; mthilo = 2'b00; a = 32'h1234;
    #1 chk("clr_busy", {31'd0, busy}, 32'd0);
    tick();
    clr = 1'b0; mthilo = 2'b10;
    chk("clr_idle_busy", {31'd0, busy}, 32'd0);
    chk("clr_hi", hi, 32'hAAAA);
    chk("clr_lo", lo, 32'hBBBB);
    run_op(4'd0, 32'd5, 32'd6);

    // Abort on the completion edge suppresses the commit
    start = 1'b1; op = 4'd0; a = 32'd7; b = 32'd7;
    tick();
    start = 1'b0; op = 4'hF;
    for (int c = 1; c < MUL_N; c++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_commit_busy", {31'd0, busy}, 32'd0);
    chk("clr_commit_hi", hi, m_hi);
    chk("clr_commit_lo", lo, m_lo);

    // start with clr in IDLE is suppressed
    start = 1'b1; op = 4'd1; a = 32'd9; b = 32'd9; clr = 1'b1;
    #1 chk("clr_start_busy", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0; clr = 1'b0; op = 4'hF;
    chk("clr_start_idle", {31'd0, busy}, 32'd0);
    for (int c = 0; c <= MUL_N; c++) tick();
    chk("clr_start_hi", hi, m_hi);
    chk("clr_start_lo", lo, m_lo);

    // Reserved and none ops are dropped
    start = 1'b1; op = 4'h9; a = 32'd2; b = 32'd2;
    #1 chk("rsv_busy", {31'd0, busy}, 32'd0);
    op = 4'hF;
    #1 chk("none_busy", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0;
    chk("rsv_idle", {31'd0, busy}, 32'd0);
    chk("rsv_hi", hi, m_hi);

    // start and mthilo together: start wins
    mthilo = 2'b00;
    run_op(4'd0, 32'h10, 32'h10);
    mthilo = 2'b10;
    tick();
    chk("start_wins_hi", hi, m_hi);

    // start and mthilo during RUN are ignored
    set_hilo(32'd0, 32'd0);
    start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; op = 4'hF;
    tick();
    mthilo = 2'b00; a = 32'hDEAD;
    tick();
    mthilo = 2'b10;
    start = 1'b1; op = 4'd0; a = 32'd9; b = 32'd9;
    #1 chk("run_start_busy", {31'd0, busy}, 32'd1);
    tick();
    start = 1'b0; op = 4'hF;
    for (int c = 4; c <= DIV_N; c++) tick();
    model_exec(4'd3, 32'd100, 32'd7);
    chk("run_ign_busy", {31'd0, busy}, 32'd0);
    chk("run_ign_hi", hi, 32'd2);
    chk("run_ign_lo", lo, 32'd14);
    tick();
    chk("run_ign_no_second", {31'd0, busy}, 32'd0);

    // rdata shows registered HI with no bypass of a same-cycle write
    mfsel = 2'b01; mthilo = 2'b00; a = 32'h5555;
    #1 chk("nobypass_rdata", rdata, 32'd2);
    tick();
    mthilo = 2'b10;
    chk("mthi_rdata", rdata, 32'h5555);
    m_hi = 32'h5555;
    mfsel = 2'b11;
    #1 chk("mfsel_rsv_rdata", rdata, 32'd0);
    mfsel = 2'b00;

    // Asynchronous reset in the middle of a divide
    set_hilo(32'h77, 32'h88);
    start = 1'b1; op = 4'd2; a = 32'd50; b = 32'd3;
    tick();
    start = 1'b0; op = 4'hF;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < DIV_N; c++) tick();
    chk("arst_after_busy", {31'd0, busy}, 32'd0);
    chk("arst_after_lo", lo, 32'd0);
    run_op(4'd3, 32'd100, 32'd7);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      int          mode;
      if ($urandom_range(0, 3) == 0) set_hilo($urandom, $urandom);
      ro   = 4'($urandom_range(0, 7));
      ra   = $urandom;
      mode = $urandom_range(0, 5);
      if (mode == 0)      rb = 32'd0;
      else if (mode == 1) rb = 32'($urandom_range(1, 20));
      else if (mode == 2) rb = 32'hFFFFFFFF;
      else                rb = $urandom;
      run_op(ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
